warp_fetch_unit: RTL and testbench

- Instruction fetch stage for one core. Holds a PC per warp and picks the next active warp round-robin.
- Issues one instruction-memory request at a time and delivers fetched instructions to decode through a one-entry output register.
- Applies redirects from the branch predictor's decode-stage prediction and execute-stage misprediction outputs.
- Drives the predictor's fetch_valid / fetch_warp_id / fetch_pc inputs.

---
 rtl/pkg_opengpu.sv | 16 +
 rtl/warp_rr_arbiter.sv | 29 ++
 rtl/warp_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_warp_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_opengpu.sv
// Shared OpenGPU core parameters and the fetch-stage state type.
package pkg_opengpu;

    localparam int unsigned WARPS_PER_CORE = 4;
    localparam int unsigned WARP_ID_WIDTH  = 2;
    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned INSTR_WIDTH    = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/warp_rr_arbiter.sv
// Combinational round-robin pick: first set bit of active after rr_ptr, wrapping.
module warp_rr_arbiter
    import pkg_opengpu::*;
#(
    parameter int unsigned NUM_WARPS = WARPS_PER_CORE
) (
    input  logic [NUM_WARPS-1:0]     active,
    input  logic [WARP_ID_WIDTH-1:0] rr_ptr,
    output logic                     found,
    output logic [WARP_ID_WIDTH-1:0] warp_id
);

    logic [WARP_ID_WIDTH-1:0] idx;

    // Scan from the far end back towards rr_ptr+1 so the nearest hit is written last.
    always_comb begin
        found   = 1'b0;
        warp_id = '0;
        idx     = '0;
        for (int unsigned i = NUM_WARPS; i >= 1; i--) begin
            idx = WARP_ID_WIDTH'((int'(rr_ptr) + i) % NUM_WARPS);
            if (active[idx]) begin
                found   = 1'b1;
                warp_id = idx;
            end
        end
    end

endmodule

// File: rtl/warp_fetch_unit.sv
// Per-warp PC tracking, round-robin warp selection and single-outstanding instruction fetch.
module warp_fetch_unit #(
    parameter int unsigned NUM_WARPS   = pkg_opengpu::WARPS_PER_CORE,
    parameter int unsigned INSTR_WIDTH = pkg_opengpu::INSTR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 launch_valid,
    input  logic [pkg_opengpu::WARP_ID_WIDTH-1:0] launch_warp_id,
    input  logic [pkg_opengpu::ADDR_WIDTH-1:0]    launch_pc,
    input  logic                                 halt_valid,
    input  logic [pkg_opengpu::WARP_ID_WIDTH-1:0] halt_warp_id,
    input  logic [pkg_opengpu::WARP_ID_WIDTH-1:0] decode_warp_id,
    input  logic                                 predict_taken,
    input  logic [pkg_opengpu::ADDR_WIDTH-1:0]    predict_target,
    input  logic                                 misprediction,
    input  logic [pkg_opengpu::WARP_ID_WIDTH-1:0] mispredict_warp_id,
    input  logic [pkg_opengpu::ADDR_WIDTH-1:0]    correct_pc,
    output logic                                 imem_req_valid,
    input  logic                                 imem_req_ready,
    output logic [pkg_opengpu::ADDR_WIDTH-1:0]    imem_req_addr,
    input  logic                                 imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0]               imem_rsp_data,
    output logic                                 fetch_valid,
    output logic [pkg_opengpu::WARP_ID_WIDTH-1:0] fetch_warp_id,
    output logic [pkg_opengpu::ADDR_WIDTH-1:0]    fetch_pc,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [pkg_opengpu::WARP_ID_WIDTH-1:0] out_warp_id,
    output logic [pkg_opengpu::ADDR_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0]               out_instr
);

    import pkg_opengpu::*;

    fetch_state_e             state_q;
    logic [WARP_ID_WIDTH-1:0] cur_warp_q;
    logic [ADDR_WIDTH-1:0]    cur_pc_q;
    logic [WARP_ID_WIDTH-1:0] rr_ptr_q;
    logic                     discard_q;
    logic [NUM_WARPS-1:0]     active_q;
    logic [ADDR_WIDTH-1:0]    pc_q [NUM_WARPS];

    logic [NUM_WARPS-1:0]     active_d;
    logic [ADDR_WIDTH-1:0]    pc_d [NUM_WARPS];
    logic [NUM_WARPS-1:0]     squash;
    logic [NUM_WARPS-1:0]     halt_kill;
    logic                     req_fire;
    logic                     cur_squash;
    logic                     pick_found;
    logic [WARP_ID_WIDTH-1:0] pick_warp;

    assign fetch_valid = imem_req_valid;
    assign fetch_pc    = imem_req_addr;

    // Per-warp redirect resolution: misprediction > launch > predict > sequential increment.
    always_comb begin
        req_fire = imem_req_valid && imem_req_ready;
        for (int w = 0; w < NUM_WARPS; w++) begin
            logic mis_hit, pred_hit, launch_hit, halt_hit;
            mis_hit    = misprediction && (mispredict_warp_id == WARP_ID_WIDTH'(w));
            pred_hit   = predict_taken && (decode_warp_id == WARP_ID_WIDTH'(w));
            launch_hit = launch_valid && (launch_warp_id == WARP_ID_WIDTH'(w));
            halt_hit   = halt_valid && (halt_warp_id == WARP_ID_WIDTH'(w));

            active_d[w]  = active_q[w];
            if (launch_hit) begin
                active_d[w] = 1'b1;
            end else if (halt_hit) begin
                active_d[w] = 1'b0;
            end
            halt_kill[w] = halt_hit && !launch_hit;
            squash[w]    = mis_hit || pred_hit || halt_kill[w] || (launch_hit && active_q[w]);

            pc_d[w] = pc_q[w];
            if (mis_hit) begin
                pc_d[w] = correct_pc;
            end else if (launch_hit) begin
                pc_d[w] = launch_pc;
            end else if (pred_hit) begin
                pc_d[w] = predict_target;
            end else if (req_fire && (cur_warp_q == WARP_ID_WIDTH'(w))) begin
                pc_d[w] = cur_pc_q + ADDR_WIDTH'(4);
            end
        end
        cur_squash = squash[cur_warp_q];
    end

    // A warp being halted this cycle must not be picked.
    warp_rr_arbiter #(
        .NUM_WARPS (NUM_WARPS)
    ) u_arbiter (
        .active  (active_q & ~halt_kill),
        .rr_ptr  (rr_ptr_q),
        .found   (pick_found),
        .warp_id (pick_warp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cur_warp_q     <= '0;
            cur_pc_q       <= '0;
            rr_ptr_q       <= '0;
            discard_q      <= 1'b0;
            active_q       <= '0;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= '0;
            fetch_warp_id  <= '0;
            out_valid      <= 1'b0;
            out_warp_id    <= '0;
            out_pc         <= '0;
            out_instr      <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w] <= '0;
            end
        end else begin
            active_q <= active_d;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w] <= pc_d[w];
            end

            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        cur_warp_q     <= pick_warp;
                        cur_pc_q       <= pc_d[pick_warp];
                        rr_ptr_q       <= pick_warp;
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= pc_d[pick_warp];
                        fetch_warp_id  <= pick_warp;
                        state_q        <= StReq;
                    end
                end
                StReq: begin
                    if (cur_squash) begin
                        imem_req_valid <= 1'b0;
                        state_q        <= StIdle;
                    end else if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        discard_q      <= 1'b0;
                        state_q        <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rsp_valid) begin
                        if (discard_q || cur_squash) begin
                            discard_q <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            out_valid   <= 1'b1;
                            out_warp_id <= cur_warp_q;
                            out_pc      <= cur_pc_q;
                            out_instr   <= imem_rsp_data;
                            state_q     <= StHold;
                        end
                    end else if (cur_squash) begin
                        discard_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (cur_squash || out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_warp_fetch_unit.sv
// Directed bench for warp_fetch_unit with a one-cycle behavioural instruction memory.
module tb_warp_fetch_unit;
    import pkg_opengpu::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        launch_valid, halt_valid, predict_taken, misprediction;
    logic [1:0]  launch_warp_id, halt_warp_id, decode_warp_id, mispredict_warp_id;
    logic [31:0] launch_pc, predict_target, correct_pc;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        fetch_valid;
    logic [1:0]  fetch_warp_id;
    logic [31:0] fetch_pc;
    logic        out_valid, out_ready;
    logic [1:0]  out_warp_id;
    logic [31:0] out_pc, out_instr;

    int n_vec  = 0;
    int n_miss = 0;

    logic        rsp_stall = 1'b0;
    logic        pending   = 1'b0;
    logic [31:0] pend_addr = '0;

    logic [31:0] hs_addr_q [$];
    logic [31:0] hs_fpc_q  [$];
    logic [1:0]  hs_w_q    [$];
    logic [31:0] out_pc_q  [$];
    logic [1:0]  out_w_q   [$];
    logic [31:0] out_i_q   [$];

    always #5 clk = ~clk;

    warp_fetch_unit u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .launch_valid       (launch_valid),
        .launch_warp_id     (launch_warp_id),
        .launch_pc          (launch_pc),
        .halt_valid         (halt_valid),
        .halt_warp_id       (halt_warp_id),
        .decode_warp_id     (decode_warp_id),
        .predict_taken      (predict_taken),
        .predict_target     (predict_target),
        .misprediction      (misprediction),
        .mispredict_warp_id (mispredict_warp_id),
        .correct_pc         (correct_pc),
        .imem_req_valid     (imem_req_valid),
        .imem_req_ready     (imem_req_ready),
        .imem_req_addr      (imem_req_addr),
        .imem_rsp_valid     (imem_rsp_valid),
        .imem_rsp_data      (imem_rsp_data),
        .fetch_valid        (fetch_valid),
        .fetch_warp_id      (fetch_warp_id),
        .fetch_pc           (fetch_pc),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_warp_id        (out_warp_id),
        .out_pc             (out_pc),
        .out_instr          (out_instr)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return 32'hC0DE_0000 ^ addr;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory: always ready, answers one cycle after the accepted request.
    initial begin
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
            end else begin
                if (pending && !rsp_stall) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = instr_of(pend_addr);
                    pending        = 1'b0;
                end
                if (imem_req_valid) begin
                    pending   = 1'b1;
                    pend_addr = imem_req_addr;
                end
            end
        end
    end

    // Monitor: log request handshakes and accepted instructions mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && imem_req_valid && imem_req_ready) begin
                hs_addr_q.push_back(imem_req_addr);
                hs_fpc_q.push_back(fetch_pc);
                hs_w_q.push_back(fetch_warp_id);
            end
            if (rst_n && out_valid && out_ready) begin
                out_pc_q.push_back(out_pc);
                out_w_q.push_back(out_warp_id);
                out_i_q.push_back(out_instr);
            end
        end
    end

    task automatic clear_logs();
        hs_addr_q.delete(); hs_fpc_q.delete(); hs_w_q.delete();
        out_pc_q.delete();  out_w_q.delete();  out_i_q.delete();
    endtask

    task automatic do_launch(input logic [1:0] w, input logic [31:0] pc);
        @(negedge clk);
        launch_valid = 1'b1; launch_warp_id = w; launch_pc = pc;
        @(negedge clk);
        launch_valid = 1'b0;
    endtask

    task automatic do_halt(input logic [1:0] w);
        @(negedge clk);
        halt_valid = 1'b1; halt_warp_id = w;
        @(negedge clk);
        halt_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
        clear_logs();
    endtask

    task automatic wait_hs(input int n);
        int t = 0;
        while (hs_addr_q.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        #3;
        check_val("hs_wait", hs_addr_q.size(), n);
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (out_pc_q.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        #3;
        check_val("out_wait", out_pc_q.size(), n);
    endtask

    initial begin
        rst_n = 1'b0;
        launch_valid = 0; halt_valid = 0; predict_taken = 0; misprediction = 0;
        launch_warp_id = 0; halt_warp_id = 0; decode_warp_id = 0; mispredict_warp_id = 0;
        launch_pc = 0; predict_target = 0; correct_pc = 0; out_ready = 1'b1;

        // Reset state, and no fetching without a launch
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_req_valid", imem_req_valid, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_req_addr", imem_req_addr, 0);
        check_val("rst_out_pc", out_pc, 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_val("idle_no_req", hs_addr_q.size(), 0);

        // Single warp, sequential fetch
        do_launch(2'd0, 32'h100);
        wait_out(3);
        if (out_pc_q.size() >= 3) begin
            check_val("seq_pc0", out_pc_q[0], 32'h100);
            check_val("seq_pc1", out_pc_q[1], 32'h104);
            check_val("seq_pc2", out_pc_q[2], 32'h108);
            check_val("seq_w2", out_w_q[2], 0);
            check_val("seq_instr0", out_i_q[0], 32'hC0DE_0100);
        end
        do_halt(2'd0);
        settle();
        repeat (6) @(negedge clk);
        check_val("halt_no_req", hs_addr_q.size(), 0);

        // Round-robin between warps 0 and 2
        do_launch(2'd0, 32'h000);
        do_launch(2'd2, 32'h200);
        wait_hs(3);
        if (hs_addr_q.size() >= 3) begin
            check_val("rr_w0", hs_w_q[0], 0);
            check_val("rr_w1", hs_w_q[1], 2);
            check_val("rr_w2", hs_w_q[2], 0);
            check_val("rr_pc0", hs_fpc_q[0], 32'h000);
            check_val("rr_pc1", hs_fpc_q[1], 32'h200);
            check_val("rr_pc2", hs_fpc_q[2], 32'h004);
        end
        do_halt(2'd0);
        do_halt(2'd2);
        settle();

        // Misprediction while waiting for the response
        rsp_stall = 1'b1;
        do_launch(2'd1, 32'h40);
        wait_hs(1);
        @(negedge clk);
        misprediction = 1'b1; mispredict_warp_id = 2'd1; correct_pc = 32'h80;
        @(negedge clk);
        misprediction = 1'b0;
        rsp_stall = 1'b0;
        wait_out(1);
        if (hs_addr_q.size() >= 2) check_val("mis_refetch", hs_addr_q[1], 32'h80);
        else check_val("mis_refetch_cnt", hs_addr_q.size(), 2);
        if (out_pc_q.size() >= 1) check_val("mis_first_out", out_pc_q[0], 32'h80);
        do_halt(2'd1);
        settle();

        // Same-cycle misprediction and predict on one warp
        rsp_stall = 1'b1;
        do_launch(2'd0, 32'h000);
        wait_hs(1);
        @(negedge clk);
        misprediction = 1'b1; mispredict_warp_id = 2'd0; correct_pc = 32'h300;
        predict_taken = 1'b1; decode_warp_id = 2'd0; predict_target = 32'h500;
        @(negedge clk);
        misprediction = 1'b0; predict_taken = 1'b0;
        rsp_stall = 1'b0;
        wait_out(1);
        if (hs_addr_q.size() >= 2) check_val("prio_refetch", hs_addr_q[1], 32'h300);
        else check_val("prio_refetch_cnt", hs_addr_q.size(), 2);
        if (out_pc_q.size() >= 1) check_val("prio_out", out_pc_q[0], 32'h300);
        do_halt(2'd0);
        settle();

        // Decode back-pressure holds the output register
        out_ready = 1'b0;
        do_launch(2'd3, 32'h3C0);
        begin
            int t = 0;
            while (!out_valid && t < 50) begin
                @(negedge clk);
                #3;
                t++;
            end
        end
        check_val("hold_valid", out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            #3;
            check_val("hold_pc", out_pc, 32'h3C0);
            check_val("hold_w", out_warp_id, 3);
            check_val("hold_instr", out_instr, 32'hC0DE_03C0);
            check_val("hold_no_req", imem_req_valid, 0);
        end
        clear_logs();
        out_ready = 1'b1;
        wait_hs(1);
        if (hs_addr_q.size() >= 1) check_val("hold_next_pc", hs_addr_q[0], 32'h3C4);

        // Asynchronous reset while in WAIT
        rsp_stall = 1'b1;
        clear_logs();
        wait_hs(1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_req_valid", imem_req_valid, 0);
        check_val("arst_out_valid", out_valid, 0);
        check_val("arst_req_addr", imem_req_addr, 0);
        check_val("arst_fetch_w", fetch_warp_id, 0);
        check_val("arst_out_pc", out_pc, 0);
        check_val("arst_out_instr", out_instr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_stall = 1'b0;
        clear_logs();
        repeat (10) @(negedge clk);
        check_val("arst_no_req", hs_addr_q.size(), 0);
        do_launch(2'd1, 32'h10);
        wait_out(1);
        if (out_pc_q.size() >= 1) begin
            check_val("arst_relaunch_pc", out_pc_q[0], 32'h10);
            check_val("arst_relaunch_w", out_w_q[0], 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
